// File: rtl/vblank_scheduler.sv
// ---------------------------------------------------------------------------
// vblank_scheduler
//
// Frame-synchronous access scheduler for the Ball and Paddle game logic.
// Each vsync falling edge opens an update window of WINDOW_CYC px_clk cycles.
// Inside the window, the shared game-state registers are granted exclusively
// and round-robin to up to N_REQ requesters, at most once each per window.
// Outside the window nothing is granted, so the picture is never modified
// while it is being scanned out.
//
// Ports
//   px_clk     in   pixel clock shared with the VGA timing generator
//   rst_n      in   asynchronous active-low reset
//   vsync      in   VSYNC, idles high, one low pulse per frame
//   req        in   [N_REQ] level request per requester (bit 0 = requester 0)
//   done       in   [N_REQ] requester finished; only the granted bit matters
//   grant      out  [N_REQ] one-hot exclusive grant (registered)
//   frame_tick out  one-cycle pulse when the window opens
//   busy       out  high while the window is open
//   overrun    out  one-cycle pulse when the window closes on an active grant
//   timeout    out  one-cycle pulse on watchdog expiry
//
// Optional feature
//   VBLANK_SCHED_WATCHDOG_EN : when defined, a per-grant slot counter takes the
//   grant away from a requester after MAX_SLOT cycles without done, pulses
//   timeout and marks that requester served. When undefined, timeout is tied
//   low and a grant lasts until done or window close.
// ---------------------------------------------------------------------------
module vblank_scheduler #(
  parameter int N_REQ      = 3,
  parameter int WINDOW_CYC = 20000,
  parameter int MAX_SLOT   = 255
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] WIN_LOAD = 16'(WINDOW_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  // (base + off) mod N_REQ, for off in 0..N_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Index to one-hot requester vector
  function automatic logic [N_REQ-1:0] idx_to_oh(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             vsync_q_r;
  logic [15:0]      win_cnt_r;
  logic [15:0]      win_cnt_nxt_s;
  logic [N_REQ-1:0] served_r;
  logic [N_REQ-1:0] served_nxt_s;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] rr_ptr_nxt_s;
  logic [PTR_W-1:0] gnt_idx_r;
  logic [PTR_W-1:0] gnt_idx_nxt_s;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] grant_nxt_s;
  logic             frame_tick_r;
  logic             frame_tick_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             overrun_r;
  logic             overrun_nxt_s;
  logic             timeout_r;
  logic             timeout_nxt_s;

  logic             vsync_fall_s;
  logic             win_zero_s;
  logic [N_REQ-1:0] eligible_s;
  logic             pick_found_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             done_hit_s;
  logic             wd_expire_s;
  logic             grant_load_s;

  assign vsync_fall_s = vsync_q_r & ~vsync;
  assign win_zero_s   = (win_cnt_r == 16'd0);
  assign eligible_s   = req & ~served_r;
  // Only the currently granted requester's done bit is looked at.
  assign done_hit_s   = done[gnt_idx_r];

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping.
  // Scanning from the farthest offset back lets the nearest one win.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (eligible_s[wrap_add(rr_ptr_r, k)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = wrap_add(rr_ptr_r, k);
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

`ifdef VBLANK_SCHED_WATCHDOG_EN
  localparam int SLOT_W = $clog2(MAX_SLOT + 1);

  logic [SLOT_W-1:0] slot_cnt_r;

  // Expiry after MAX_SLOT cycles of a grant: counter starts at 0 on the grant
  // edge and the grant is withdrawn on the edge that sees MAX_SLOT-1.
  assign wd_expire_s = (slot_cnt_r == SLOT_W'(MAX_SLOT - 1));

  // Per-grant slot counter
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
    end else if (grant_load_s) begin
      slot_cnt_r <= '0;
    end else if ((state_r == ST_GRANT) && !wd_expire_s) begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r;
    end
  end
`else
  // No watchdog: a grant never expires on its own (MAX_SLOT is irrelevant).
  assign wd_expire_s = (MAX_SLOT < 0);
`endif

  // State register
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; window close takes priority over done and watchdog
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vsync_fall_s) begin
          state_nxt_s = ST_OPEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (win_zero_s) begin
          state_nxt_s = ST_IDLE;
        end else if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      ST_GRANT: begin
        if (win_zero_s) begin
          state_nxt_s = ST_IDLE;
        end else if (done_hit_s || wd_expire_s) begin
          state_nxt_s = ST_OPEN;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values, registered below
  always_comb begin
    grant_nxt_s      = '0;
    frame_tick_nxt_s = 1'b0;
    overrun_nxt_s    = 1'b0;
    timeout_nxt_s    = 1'b0;
    busy_nxt_s       = (state_nxt_s != ST_IDLE);
    served_nxt_s     = served_r;
    rr_ptr_nxt_s     = rr_ptr_r;
    gnt_idx_nxt_s    = gnt_idx_r;
    win_cnt_nxt_s    = win_cnt_r;
    grant_load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A falling edge seen while the window is open never reaches here,
        // so it cannot restart the window.
        if (vsync_fall_s) begin
          win_cnt_nxt_s    = WIN_LOAD;
          served_nxt_s     = '0;
          frame_tick_nxt_s = 1'b1;
        end else begin
          win_cnt_nxt_s    = win_cnt_r;
        end
      end
      ST_OPEN: begin
        if (win_zero_s) begin
          win_cnt_nxt_s = win_cnt_r;
        end else begin
          win_cnt_nxt_s = win_cnt_r - 16'd1;
          if (pick_found_s) begin
            grant_nxt_s   = idx_to_oh(pick_idx_s);
            gnt_idx_nxt_s = pick_idx_s;
            grant_load_s  = 1'b1;
          end else begin
            grant_nxt_s   = '0;
          end
        end
      end
      ST_GRANT: begin
        if (win_zero_s) begin
          // Cut off by window close: not served, pointer untouched.
          overrun_nxt_s = 1'b1;
        end else begin
          win_cnt_nxt_s = win_cnt_r - 16'd1;
          if (done_hit_s || wd_expire_s) begin
            served_nxt_s  = served_r | idx_to_oh(gnt_idx_r);
            rr_ptr_nxt_s  = wrap_add(gnt_idx_r, 1);
            timeout_nxt_s = wd_expire_s & ~done_hit_s;
          end else begin
            grant_nxt_s   = grant_r;
          end
        end
      end
      default: begin
        grant_nxt_s = '0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q_r    <= 1'b1;
      win_cnt_r    <= 16'd0;
      served_r     <= '0;
      rr_ptr_r     <= '0;
      gnt_idx_r    <= '0;
      grant_r      <= '0;
      frame_tick_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      vsync_q_r    <= vsync;
      win_cnt_r    <= win_cnt_nxt_s;
      served_r     <= served_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      gnt_idx_r    <= gnt_idx_nxt_s;
      grant_r      <= grant_nxt_s;
      frame_tick_r <= frame_tick_nxt_s;
      busy_r       <= busy_nxt_s;
      overrun_r    <= overrun_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

  assign grant      = grant_r;
  assign frame_tick = frame_tick_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_vblank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vblank_scheduler
//
// Directed bench for vblank_scheduler with a short window (WINDOW_CYC=100)
// and MAX_SLOT=16. Each frame is driven by run_frame, which pulses vsync,
// plays requesters that raise done a fixed number of cycles into their
// grant, and records grant order, start/end cycles and pulse counts.
// Cycle c counts px_clk edges after the edge that opened the window.
// Expectations follow the watchdog macro when it is defined.
// ---------------------------------------------------------------------------
module tb_vblank_scheduler;

  localparam int WIN = 100;

  logic       px_clk;
  logic       rst_n;
  logic       vsync;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic       frame_tick;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int checks;
  int errors;

  int g_seq   [8];
  int g_start [8];
  int g_end   [8];
  int g_n, ov_n, ov_c, tm_n, tm_c, ft_n, end_c;

  vblank_scheduler #(
    .N_REQ     (3),
    .WINDOW_CYC(WIN),
    .MAX_SLOT  (16)
  ) dut (
    .px_clk    (px_clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .frame_tick(frame_tick),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  // One window: requesters in req_v raise done on cycle dly of their grant
  // (dly=0: never). noise drives done high on every non-granted bit.
  // spur_c > 0 puts a second vsync falling edge on that cycle.
  task automatic run_frame(input logic [2:0] req_v, input int dly,
                           input bit noise, input int spur_c);
    logic [2:0] prev;
    logic [2:0] g;
    int         hold;
    g_n = 0; ov_n = 0; ov_c = -1; tm_n = 0; tm_c = -1; ft_n = 0; end_c = -1;
    for (int i = 0; i < 8; i++) begin
      g_seq[i] = 0; g_start[i] = -1; g_end[i] = -1;
    end
    req  = req_v;
    done = 3'b000;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check("open_frame_tick", frame_tick, 1);
    check("open_busy", busy, 1);
    prev = 3'b000;
    hold = 0;
    for (int c = 1; c <= 3 * WIN; c++) begin
      vsync = (c == spur_c) ? 1'b0 : 1'b1;
      tick();
      g = grant;
      if (g != 3'b000 && g != prev) begin
        if (prev != 3'b000 && g_n > 0 && g_n <= 8) g_end[g_n-1] = c;
        if (g_n < 8) begin
          g_seq[g_n]   = int'(g);
          g_start[g_n] = c;
        end
        g_n++;
        hold = 1;
      end else if (g != 3'b000) begin
        hold++;
      end else begin
        if (prev != 3'b000 && g_n > 0 && g_n <= 8) g_end[g_n-1] = c;
        hold = 0;
      end
      if (overrun) begin ov_n++; if (ov_c < 0) ov_c = c; end
      if (timeout) begin tm_n++; if (tm_c < 0) tm_c = c; end
      if (frame_tick) ft_n++;
      done = ((dly > 0 && g != 3'b000 && hold == dly) ? g : 3'b000) |
             (noise ? ~g : 3'b000);
      prev = g;
      if (!busy) begin
        end_c = c;
        break;
      end
    end
    done  = 3'b000;
    vsync = 1'b1;
    check("window_len", end_c, WIN);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    vsync  = 1'b1;
    req    = 3'b000;
    done   = 3'b000;

    // Reset held with vsync toggling: everything quiet
    for (int i = 0; i < 6; i++) begin
      vsync = ~vsync;
      tick();
    end
    check("reset_outputs", int'({grant, frame_tick, busy, overrun, timeout}), 0);
    vsync = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_outputs", int'({grant, frame_tick, busy, overrun, timeout}), 0);

    // Empty frame: single-cycle frame_tick, busy spans the window
    run_frame(3'b000, 0, 1'b0, 0);
    check("empty_ft_once", ft_n, 0);
    check("empty_no_grant", g_n, 0);

    // Round-robin over all three, done 5 cycles into each grant
    run_frame(3'b111, 5, 1'b0, 0);
    check("rr_count", g_n, 3);
    check("rr_g0", g_seq[0], 1);
    check("rr_g1", g_seq[1], 2);
    check("rr_g2", g_seq[2], 4);
    check("rr_first_lat", g_start[0], 1);
    check("rr_width", g_end[0] - g_start[0], 5);
    check("rr_gap01", g_start[1] - g_end[0], 1);
    check("rr_gap12", g_start[2] - g_end[1], 1);
    check("rr_no_overrun", ov_n, 0);

    // Pointer wrapped back to requester 0
    run_frame(3'b111, 5, 1'b0, 0);
    check("rr2_g0", g_seq[0], 1);
    check("rr2_count", g_n, 3);

    // Fairness across frames: 0,1 then 2,0,1
    run_frame(3'b011, 5, 1'b0, 0);
    check("fairA_count", g_n, 2);
    check("fairA_g1", g_seq[1], 2);
    run_frame(3'b111, 5, 1'b0, 0);
    check("fairB_g0", g_seq[0], 4);
    check("fairB_g1", g_seq[1], 1);
    check("fairB_g2", g_seq[2], 2);

    // Hung requesters: no done at all
    run_frame(3'b011, 0, 1'b0, 0);
    check("hung_g0", g_seq[0], 1);
`ifdef VBLANK_SCHED_WATCHDOG_EN
    check("wd_width", g_end[0] - g_start[0], 16);
    check("wd_timeout_at", tm_c, 17);
    check("wd_timeouts", tm_n, 2);
    check("wd_g1", g_seq[1], 2);
    check("wd_g1_start", g_start[1], 18);
    check("wd_no_overrun", ov_n, 0);
`else
    check("ovr_count", g_n, 1);
    check("ovr_grant_end", g_end[0], WIN);
    check("ovr_pulses", ov_n, 1);
    check("ovr_at", ov_c, WIN);
    check("ovr_no_timeout", tm_n, 0);
`endif
    tick();
    check("pulse_one_cycle", int'({overrun, timeout}), 0);

    // Next frame restarts at requester 0 (pointer unchanged by overrun)
    run_frame(3'b011, 3, 1'b0, 0);
    check("after_g0", g_seq[0], 1);
    check("after_g1", g_seq[1], 2);
    check("after_width", g_end[0] - g_start[0], 3);

    // Spurious vsync edge at cycle 50 plus done noise on idle requesters
    run_frame(3'b111, 4, 1'b1, 50);
    check("spur_no_tick", ft_n, 0);
    check("spur_g0", g_seq[0], 4);
    check("spur_g1", g_seq[1], 1);
    check("spur_g2", g_seq[2], 2);
    check("spur_width", g_end[0] - g_start[0], 4);

    // Reset in the middle of a grant
    req   = 3'b001;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    check("mid_grant_before", grant, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_grant", grant, 0);
    check("mid_reset_overrun", overrun, 0);
    check("mid_reset_busy", busy, 0);
    tick();
    check("mid_reset_outputs", int'({grant, frame_tick, busy, overrun, timeout}), 0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
